// File: rtl/regfile_dump_tx_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_tx_if
//   Groups the signals between the register-file dump engine and its
//   surroundings: the dump request/status pair, the register file's debug
//   read port, the UART line, and a debug view of the engine's FSM.
//
//   Handshake: the host raises start (a level). The engine samples it only
//   while idle; busy rises the cycle after acceptance and stays high until
//   the cycle in which done pulses for exactly one cycle. start seen while
//   busy is dropped, not queued. On the read side, dbg_read is a one-cycle
//   strobe with dbg_addr held stable from the cycle before it until the
//   cycle the returned dbg_data is captured, two cycles after the strobe.
//
//   Modports:
//     master - the dump engine (drives the debug read port, tx and status)
//     slave  - the host side and the register file
// ---------------------------------------------------------------------------
interface regfile_dump_tx_if;
    logic        start;
    logic [31:0] dbg_data;
    logic [4:0]  dbg_addr;
    logic        dbg_read;
    logic        tx;
    logic        busy;
    logic        done;
    logic [3:0]  fsm_state;

    modport master (
        input  start,
        input  dbg_data,
        output dbg_addr,
        output dbg_read,
        output tx,
        output busy,
        output done,
        output fsm_state
    );

    modport slave (
        output start,
        output dbg_data,
        input  dbg_addr,
        input  dbg_read,
        input  tx,
        input  busy,
        input  done,
        input  fsm_state
    );
endinterface

// File: rtl/regfile_dump_tx.sv
// ---------------------------------------------------------------------------
// regfile_dump_tx
//   Walks register addresses FIRST_REG..LAST_REG, issues one debug read per
//   address and sends each returned 32-bit word MSB byte first as four
//   UART 8N1 frames.
//
//   Ports:
//     clock - system clock, rising edge
//     reset - asynchronous, active-high
//     bus   - regfile_dump_tx_if.master: start, dbg_data (in);
//             dbg_addr, dbg_read, tx, busy, done, fsm_state (out)
// ---------------------------------------------------------------------------
module regfile_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIRST_REG    = 0,
    parameter int LAST_REG     = 31
) (
    input  logic              clock,
    input  logic              reset,
    regfile_dump_tx_if.master bus
);

    localparam int              BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]      FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0]      LAST_ADDR  = 5'(LAST_REG);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_LATCH,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT,
        S_NEXT
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          addr_q, addr_d;
    logic [31:0]         buf_q, buf_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic [7:0]          cur_byte;
    logic                bit_end;

    // Byte 0 is the most significant byte of the captured word.
    always_comb begin
        case (byte_idx_q)
            2'd0:    cur_byte = buf_q[31:24];
            2'd1:    cur_byte = buf_q[23:16];
            2'd2:    cur_byte = buf_q[15:8];
            default: cur_byte = buf_q[7:0];
        endcase
    end

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= FIRST_ADDR;
            buf_q      <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // tx_d is the line level belonging to the current state; it is
    // registered, so the line trails the FSM by one cycle. That keeps tx
    // glitch-free and makes the last stop bit end right before done.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        tx_d       = 1'b1;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = FIRST_ADDR;
                    state_d = S_SETUP;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_WAIT;
            S_WAIT:   state_d = S_LATCH;
            S_LATCH: begin
                buf_d      = bus.dbg_data;
                byte_idx_d = 2'd0;
                bit_idx_d  = 3'd0;
                baud_d     = '0;
                state_d    = S_START_BIT;
            end
            S_START_BIT: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_DATA_BITS;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA_BITS: begin
                tx_d = cur_byte[bit_idx_q];
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = S_STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP_BIT: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_START_BIT;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_NEXT: begin
                // The address never wraps: the last register ends the dump.
                if (addr_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + 5'd1;
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.dbg_addr  = addr_q;
    assign bus.dbg_read  = (state_q == S_STROBE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.tx        = tx_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_tx
//   Two engines: A dumps registers 1..2, B dumps register 31 only, both at
//   4 clocks per UART bit. Each has a register-file model with a registered
//   debug output that shows garbage outside the read window. Expected bytes
//   and read addresses are queued when a dump is requested; independent
//   monitors decode the UART line, watch read strobes and done pulses, and
//   compare against those queues.
// ---------------------------------------------------------------------------
module tb_regfile_dump_tx;

    localparam int CPB     = 4;
    localparam int A_FIRST = 1;
    localparam int A_LAST  = 2;
    localparam int B_FIRST = 31;
    localparam int B_LAST  = 31;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    regfile_dump_tx_if bus_a();
    regfile_dump_tx_if bus_b();

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(A_FIRST), .LAST_REG(A_LAST)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(B_FIRST), .LAST_REG(B_LAST)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q_a[$];
    logic [7:0]  exp_q_b[$];
    logic [4:0]  rd_q_a[$];
    logic [4:0]  rd_q_b[$];
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    int          hold_a = 0;
    int          hold_b = 0;
    int          done_cnt_a = 0;
    int          done_cnt_b = 0;
    int          bytes_a = 0;
    int          bytes_b = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic string sfx(input bit which);
        return which ? "b" : "a";
    endfunction
    function automatic logic tx_of(input bit which);
        return which ? bus_b.tx : bus_a.tx;
    endfunction
    function automatic logic rd_of(input bit which);
        return which ? bus_b.dbg_read : bus_a.dbg_read;
    endfunction
    function automatic logic [4:0] addr_of(input bit which);
        return which ? bus_b.dbg_addr : bus_a.dbg_addr;
    endfunction
    function automatic logic done_of(input bit which);
        return which ? bus_b.done : bus_a.done;
    endfunction
    function automatic logic busy_of(input bit which);
        return which ? bus_b.busy : bus_a.busy;
    endfunction

    // ---------------- register file models ----------------
    // Registered debug output: valid from the edge after the strobe for two
    // cycles, random garbage otherwise.
    always @(posedge clock) begin
        if (bus_a.dbg_read) begin
            bus_a.dbg_data <= mem_a[bus_a.dbg_addr];
            hold_a         <= 2;
        end else if (hold_a > 0) begin
            hold_a <= hold_a - 1;
        end else begin
            bus_a.dbg_data <= $urandom;
        end
    end

    always @(posedge clock) begin
        if (bus_b.dbg_read) begin
            bus_b.dbg_data <= mem_b[bus_b.dbg_addr];
            hold_b         <= 2;
        end else if (hold_b > 0) begin
            hold_b <= hold_b - 1;
        end else begin
            bus_b.dbg_data <= $urandom;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_dump(input bit which);
        int first = which ? B_FIRST : A_FIRST;
        int last  = which ? B_LAST  : A_LAST;
        for (int a = first; a <= last; a++) begin
            for (int b = 3; b >= 0; b--) begin
                if (which) exp_q_b.push_back(mem_b[a][8*b +: 8]);
                else       exp_q_a.push_back(mem_a[a][8*b +: 8]);
            end
            if (which) rd_q_b.push_back(5'(a));
            else       rd_q_a.push_back(5'(a));
        end
    endtask

    task automatic wait_done(input bit which, input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (done_of(which) !== 1'b1 && n < budget);
        if (done_of(which) !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout_%s: no done within %0d cycles", sfx(which), budget);
        end
    endtask

    // ---------------- monitors ----------------
    task automatic uart_mon(input bit which);
        logic [9:0] lv;
        logic [7:0] e;
        logic       s;
        bit         aborted;
        bit         steady;
        forever begin
            @(negedge clock);
            if (!reset && tx_of(which) == 1'b0) begin
                aborted = 0;
                steady  = 1;
                lv      = '0;
                for (int k = 0; k < 10 && !aborted; k++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (k != 0 || c != 0) @(negedge clock);
                        if (reset) begin
                            aborted = 1;
                        end else begin
                            s = tx_of(which);
                            if (c == 0) lv[k] = s;
                            else if (s !== lv[k]) steady = 0;
                        end
                    end
                end
                if (!aborted) begin
                    if ((which ? exp_q_b.size() : exp_q_a.size()) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL uart_extra_byte_%s: got frame %b, expected none", sfx(which), lv);
                    end else begin
                        if (which) begin
                            e = exp_q_b.pop_front();
                            bytes_b++;
                        end else begin
                            e = exp_q_a.pop_front();
                            bytes_a++;
                        end
                        check($sformatf("uart_frame_%s", sfx(which)), 32'(lv), 32'({1'b1, e, 1'b0}));
                        check($sformatf("uart_bit_width_%s", sfx(which)), 32'(steady), 32'd1);
                    end
                end
            end
        end
    endtask

    task automatic rd_mon(input bit which);
        logic       prev_rd = 1'b0;
        logic [4:0] prev_ad = '0;
        logic [4:0] hold_ad = '0;
        logic [4:0] e;
        int         left = 0;
        logic       rd;
        logic [4:0] ad;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_rd = 1'b0;
                left    = 0;
            end else begin
                rd = rd_of(which);
                ad = addr_of(which);
                if (rd) begin
                    check($sformatf("rd_one_cycle_%s", sfx(which)), 32'(prev_rd), 32'd0);
                    check($sformatf("rd_addr_setup_%s", sfx(which)), 32'(ad), 32'(prev_ad));
                    if ((which ? rd_q_b.size() : rd_q_a.size()) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rd_unexpected_%s: read at addr %0d, expected no read", sfx(which), ad);
                    end else begin
                        e = which ? rd_q_b.pop_front() : rd_q_a.pop_front();
                        check($sformatf("rd_addr_%s", sfx(which)), 32'(ad), 32'(e));
                    end
                    hold_ad = ad;
                    left    = 2;
                end else if (left > 0) begin
                    check($sformatf("rd_addr_hold_%s", sfx(which)), 32'(ad), 32'(hold_ad));
                    left--;
                end
                prev_rd = rd;
                prev_ad = ad;
            end
        end
    endtask

    task automatic done_mon(input bit which);
        logic prev = 1'b0;
        logic d;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev = 1'b0;
            end else begin
                d = done_of(which);
                if (d) begin
                    check($sformatf("done_one_cycle_%s", sfx(which)), 32'(prev), 32'd0);
                    check($sformatf("busy_at_done_%s", sfx(which)), 32'(busy_of(which)), 32'd0);
                    check($sformatf("bytes_left_at_done_%s", sfx(which)),
                          32'(which ? exp_q_b.size() : exp_q_a.size()), 32'd0);
                    check($sformatf("reads_left_at_done_%s", sfx(which)),
                          32'(which ? rd_q_b.size() : rd_q_a.size()), 32'd0);
                    if (which) done_cnt_b++;
                    else       done_cnt_a++;
                end
                prev = d;
            end
        end
    endtask

    initial uart_mon(1'b0);
    initial uart_mon(1'b1);
    initial rd_mon(1'b0);
    initial rd_mon(1'b1);
    initial done_mon(1'b0);
    initial done_mon(1'b1);

    // ---------------- stimulus ----------------
    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        mem_a[1]  = 32'hFFFF_FFE2;
        mem_a[2]  = 32'h0000_0038;
        mem_b[31] = 32'h1234_5678;

        // Reset values
        repeat (3) @(negedge clock);
        check("reset_tx_a",    32'(bus_a.tx), 32'd1);
        check("reset_busy_a",  32'(bus_a.busy), 32'd0);
        check("reset_done_a",  32'(bus_a.done), 32'd0);
        check("reset_read_a",  32'(bus_a.dbg_read), 32'd0);
        check("reset_addr_a",  32'(bus_a.dbg_addr), 32'd1);
        check("reset_tx_b",    32'(bus_b.tx), 32'd1);
        check("reset_addr_b",  32'(bus_b.dbg_addr), 32'd31);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Run 1: fixed words, latency of the first transaction
        push_dump(1'b0);
        bus_a.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus_a.start = 1'b0;
        check("lat_busy_k0", 32'(bus_a.busy), 32'd1);
        check("lat_read_k0", 32'(bus_a.dbg_read), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            case (k)
                1: begin
                    check("lat_read_k1", 32'(bus_a.dbg_read), 32'd1);
                    check("lat_addr_k1", 32'(bus_a.dbg_addr), 32'd1);
                end
                2: check("lat_read_k2", 32'(bus_a.dbg_read), 32'd0);
                4: check("lat_tx_k4",   32'(bus_a.tx), 32'd1);
                5: check("lat_tx_k5",   32'(bus_a.tx), 32'd0);
                default: ;
            endcase
        end
        wait_done(1'b0, 400);
        repeat (20) @(negedge clock);
        check("run1_done_count", 32'(done_cnt_a), 32'd1);
        check("run1_bytes", 32'(bytes_a), 32'd8);
        check("run1_idle_tx", 32'(bus_a.tx), 32'd1);

        // Run 2: random words, start toggled while busy
        mem_a[1] = $urandom;
        mem_a[2] = $urandom;
        push_dump(1'b0);
        bus_a.start = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            bus_a.start = 1'($urandom_range(0, 1));
        end
        bus_a.start = 1'b0;
        wait_done(1'b0, 400);
        repeat (20) @(negedge clock);
        check("run2_done_count", 32'(done_cnt_a), 32'd2);
        check("run2_bytes", 32'(bytes_a), 32'd16);

        // Run 3: reset during the third data bit of the second byte (0x00)
        mem_a[1] = 32'hFF00_FFE2;
        push_dump(1'b0);
        bus_a.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus_a.start = 1'b0;
        repeat (58) @(negedge clock);
        check("pre_reset_tx", 32'(bus_a.tx), 32'd0);
        check("pre_reset_busy", 32'(bus_a.busy), 32'd1);
        reset = 1'b1;
        exp_q_a.delete();
        rd_q_a.delete();
        #1;
        check("mid_reset_tx", 32'(bus_a.tx), 32'd1);
        check("mid_reset_busy", 32'(bus_a.busy), 32'd0);
        check("mid_reset_addr", 32'(bus_a.dbg_addr), 32'd1);
        check("mid_reset_read", 32'(bus_a.dbg_read), 32'd0);
        check("mid_reset_done", 32'(bus_a.done), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        check("after_reset_bytes", 32'(bytes_a), 32'd17);
        mem_a[1] = 32'hFFFF_FFE2;
        push_dump(1'b0);
        bus_a.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus_a.start = 1'b0;
        wait_done(1'b0, 400);
        repeat (20) @(negedge clock);
        check("run3_done_count", 32'(done_cnt_a), 32'd3);
        check("run3_bytes", 32'(bytes_a), 32'd25);

        // Run 4: start held high through done re-triggers immediately
        mem_a[1] = $urandom;
        mem_a[2] = $urandom;
        push_dump(1'b0);
        bus_a.start = 1'b1;
        wait_done(1'b0, 400);
        #1;
        push_dump(1'b0);
        @(negedge clock);
        check("retrigger_busy", 32'(bus_a.busy), 32'd1);
        check("retrigger_addr", 32'(bus_a.dbg_addr), 32'd1);
        bus_a.start = 1'b0;
        wait_done(1'b0, 400);
        repeat (20) @(negedge clock);
        check("run4_done_count", 32'(done_cnt_a), 32'd5);
        check("run4_bytes", 32'(bytes_a), 32'd41);

        // Engine B: single register 31, no wrap to address 0
        for (int r = 0; r < 2; r++) begin
            if (r == 1) mem_b[31] = $urandom;
            push_dump(1'b1);
            bus_b.start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            bus_b.start = 1'b0;
            wait_done(1'b1, 250);
            repeat (50) @(negedge clock);
            check("b_addr_no_wrap", 32'(bus_b.dbg_addr), 32'd31);
            check("b_busy_idle", 32'(bus_b.busy), 32'd0);
            check("b_done_count", 32'(done_cnt_b), 32'(r + 1));
        end
        check("b_bytes", 32'(bytes_b), 32'd8);

        check("final_bytes_left_a", 32'(exp_q_a.size()), 32'd0);
        check("final_bytes_left_b", 32'(exp_q_b.size()), 32'd0);
        check("final_reads_left_a", 32'(rd_q_a.size()), 32'd0);
        check("final_reads_left_b", 32'(rd_q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
